clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Runtime-programmable integer clock divider: the parametrised successor to the fixed-ratio fabric divider in the video clocking path. It divides CLK_IN by a divisor that software can change while running. New divisors take effect only at a period boundary, so the output never glitches. BIT_SLIP shifts the output phase by one input cycle, and CE_OUT provides a matching clock enable for logic that stays in the CLK_IN domain. It sits between the PLL outputs and the pixel/line timing generators.

## Interface
- WIDTH, 8: divisor width in bits; legal divisors are 2 .. 2^WIDTH-1.
- DIV_RESET, 2: divisor loaded at reset; must be ≥2 (elaboration-time check).
- CLK_IN  in  1  input clock; all logic on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  run enable; low forces IDLE.
- DIV_IN  in  WIDTH  new divisor value.
- DIV_LOAD  in  1  one-cycle strobe; samples DIV_IN.
- BIT_SLIP  in  1  one-cycle strobe; delays output phase by one CLK_IN period.
- CLK_OUT  out  1  divided clock, registered.
- CE_OUT  out  1  one-cycle pulse coincident with each CLK_OUT rising edge, registered.
- DIV_CUR  out  WIDTH  divisor currently in effect.
- DIV_PEND  out  1  a loaded divisor is waiting for the period boundary.
- DIV_ERR  out  1  one-cycle pulse when a rejected load (DIV_IN < 2) is strobed.

## Operation
- States:
  - IDLE: cnt=0; CLK_OUT=0; CE_OUT=0.
  - RUN: counting.
  - SLIP: single-cycle counter hold.
- Counter cnt (WIDTH bits) runs 0..N-1, where N = DIV_CUR. H = N>>1.
- In RUN/SLIP, CLK_OUT = (cnt < H): high for floor(N/2) cycles, then low for ceil(N/2) cycles. N=2 gives 1 high / 1 low. N=3 gives 1 high / 2 low.
- CE_OUT = 1 exactly in cycles where cnt = 0 in RUN.
- CLK_OUT and CE_OUT are flops whose D is computed from next-state cnt and N. They are never decoded combinationally from cnt.
- Transitions:
  - IDLE→RUN when EN=1.
  - RUN→SLIP on BIT_SLIP=1.
  - SLIP→RUN unconditionally.
  - RUN/SLIP→IDLE when EN=0.
- RUN: cnt_next = (cnt == N-1) ? 0 : cnt+1.
- SLIP: cnt and CLK_OUT hold their values; CE_OUT=0.
- DIV_LOAD with DIV_IN ≥ 2:
  - In IDLE: written to DIV_CUR directly.
  - Otherwise: written to the pending register; DIV_PEND=1. A later load overwrites the pending value (latest wins).
- Wrap edge (RUN, cnt = N-1): if DIV_PEND, DIV_CUR ← pending and DIV_PEND ← 0. The new N and H govern the cycle after the edge.
- DIV_LOAD with DIV_IN < 2: ignored; DIV_ERR pulses for one cycle; pending and DIV_CUR unchanged.

## Timing
- Reset values: CLK_OUT=0, CE_OUT=0, DIV_CUR=DIV_RESET, DIV_PEND=0, DIV_ERR=0, state IDLE, cnt=0.
- EN latency: if EN is first seen high at edge k in IDLE, then after edge k: CLK_OUT=1, CE_OUT=1, cnt=0. If EN is first seen low at edge k, CLK_OUT=0 and CE_OUT=0 after edge k.
- Period: N CLK_IN cycles between CE_OUT pulses, plus one cycle per accepted BIT_SLIP.
- DIV_ERR asserts one cycle after the strobe.
- DIV_PEND rises one cycle after the strobe and falls after the wrap edge.
- Simultaneous events:
  - Valid DIV_LOAD on a wrap edge: bypasses pending and is applied at that wrap.
  - BIT_SLIP on a wrap edge: cnt holds at N-1 for one cycle; the wrap and any pending swap are deferred to the next edge.
  - BIT_SLIP while in SLIP: ignored.
  - EN=0 overrides BIT_SLIP and wrap; pending is kept and applied at the next IDLE→RUN entry.
  - DIV_LOAD with EN=0 in the same cycle: applied directly, as in IDLE.
- RST mid-operation: all outputs reach their reset values asynchronously. Pending is discarded.

## Test plan
- Reset with DIV_RESET=2, then EN=1 → CLK_OUT toggles every cycle; CE_OUT on every second cycle; DIV_CUR=2.
- Load 5 mid-period while N=4 → DIV_PEND=1 until the wrap; the old period completes; then 2 high / 3 low; CE_OUT spacing becomes 5.
- Load 7 then 3 before the boundary → only 3 takes effect; DIV_CUR=3; CLK_OUT pattern 1 high / 2 low.
- BIT_SLIP in RUN at N=4 → one CE_OUT interval is 5 cycles, then 4. A second slip during SLIP has no effect. BIT_SLIP on the wrap edge defers the pending swap by one cycle.
- DIV_LOAD with DIV_IN=0 and DIV_IN=1 → DIV_ERR pulses one cycle each; DIV_CUR and DIV_PEND unchanged.
- Assert RST mid-high-phase at N=6 with a load pending → outputs 0, DIV_CUR=DIV_RESET, DIV_PEND=0. EN low for 3 cycles → CLK_OUT=0. EN high again → CE_OUT one cycle later.

Source files
------------

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of the programmable clock divider.
// master: the side that programs the divider; slave: the divider itself.
interface clk_div_prog_if #(
  parameter int WIDTH = 8
) ();

  logic             en;
  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             bit_slip;
  logic             clk_out;
  logic             ce_out;
  logic [WIDTH-1:0] div_cur;
  logic             div_pend;
  logic             div_err;

  modport master (
    output en, div_in, div_load, bit_slip,
    input  clk_out, ce_out, div_cur, div_pend, div_err
  );

  modport slave (
    input  en, div_in, div_load, bit_slip,
    output clk_out, ce_out, div_cur, div_pend, div_err
  );

endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor
// changes at period boundaries, one-cycle phase slip and a matching
// clock enable for logic that stays in the input clock domain.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | stopped; cnt=0, clk_out=0, ce_out=0; loads go straight in
// S_RUN  | counting 0..N-1, wrap swaps in any pending divisor
// S_SLIP | one-cycle counter hold caused by bit_slip
module clk_div_prog #(
  parameter int WIDTH     = 8,
  parameter int DIV_RESET = 2
) (
  input  logic          clk_in,
  input  logic          rst,
  clk_div_prog_if.slave bus
);

  if (DIV_RESET < 2 || DIV_RESET >= (1 << WIDTH)) begin : g_bad_div_reset
    $error("clk_div_prog: DIV_RESET must lie in 2 .. 2**WIDTH-1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SLIP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_cur;
  logic [WIDTH-1:0] pend_val;
  logic             div_pend;
  logic             clk_out;
  logic             ce_out;
  logic             div_err;

  logic             load_ok;
  logic             load_bad;
  logic             wrap;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] h_cur;
  logic [WIDTH-1:0] n_next;

  // Result of one ordinary counting edge (RUN without slip, or leaving SLIP).
  logic [WIDTH-1:0] cnt_adv;
  logic             clk_adv;
  logic             ce_adv;
  logic [WIDTH-1:0] cur_adv;
  logic             pend_adv;
  logic [WIDTH-1:0] pval_adv;

  // Divisor >= 2 is equivalent to any bit above bit 0 being set.
  assign load_ok  = bus.div_load && (bus.div_in[WIDTH-1:1] != '0);
  assign load_bad = bus.div_load && (bus.div_in[WIDTH-1:1] == '0);
  assign wrap     = (cnt == div_cur - 1'b1);
  assign cnt_inc  = cnt + 1'b1;
  assign h_cur    = div_cur >> 1;
  // Divisor for a new period: a load on this very edge wins over pending.
  assign n_next   = load_ok  ? bus.div_in :
                    div_pend ? pend_val   : div_cur;

  // Next-state values for a normal counting edge, including the wrap swap.
  always_comb begin
    cnt_adv  = cnt_inc;
    clk_adv  = (cnt_inc < h_cur);
    ce_adv   = 1'b0;
    cur_adv  = div_cur;
    pend_adv = div_pend;
    pval_adv = pend_val;
    if (wrap) begin
      cnt_adv  = '0;
      cur_adv  = n_next;
      pend_adv = 1'b0;
      clk_adv  = (n_next[WIDTH-1:1] != '0);
      ce_adv   = 1'b1;
    end else if (load_ok) begin
      pend_adv = 1'b1;
      pval_adv = bus.div_in;
    end
  end

  // Sequencer: state, counter, divisor bookkeeping and registered outputs.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      div_cur  <= WIDTH'(DIV_RESET);
      pend_val <= '0;
      div_pend <= 1'b0;
      clk_out  <= 1'b0;
      ce_out   <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      div_err <= load_bad;
      if (!bus.en) begin
        // Stopping keeps any pending divisor for the next start.
        state   <= S_IDLE;
        cnt     <= '0;
        clk_out <= 1'b0;
        ce_out  <= 1'b0;
        if (load_ok) begin
          div_cur  <= bus.div_in;
          div_pend <= 1'b0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            state    <= S_RUN;
            cnt      <= '0;
            div_cur  <= n_next;
            div_pend <= 1'b0;
            clk_out  <= (n_next[WIDTH-1:1] != '0);
            ce_out   <= 1'b1;
          end
          S_RUN: begin
            if (bus.bit_slip) begin
              // Hold cnt and clk_out; the wrap (if any) moves to the next edge.
              state  <= S_SLIP;
              ce_out <= 1'b0;
              if (load_ok) begin
                div_pend <= 1'b1;
                pend_val <= bus.div_in;
              end
            end else begin
              cnt      <= cnt_adv;
              clk_out  <= clk_adv;
              ce_out   <= ce_adv;
              div_cur  <= cur_adv;
              div_pend <= pend_adv;
              pend_val <= pval_adv;
            end
          end
          S_SLIP: begin
            // A slip request here is ignored; counting resumes.
            state    <= S_RUN;
            cnt      <= cnt_adv;
            clk_out  <= clk_adv;
            ce_out   <= ce_adv;
            div_cur  <= cur_adv;
            div_pend <= pend_adv;
            pend_val <= pval_adv;
          end
          default: begin
            state   <= S_IDLE;
            cnt     <= '0;
            clk_out <= 1'b0;
            ce_out  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.clk_out  = clk_out;
  assign bus.ce_out   = ce_out;
  assign bus.div_cur  = div_cur;
  assign bus.div_pend = div_pend;
  assign bus.div_err  = div_err;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog (WIDTH=8, DIV_RESET=2).
// Inputs change 1 ns after a rising edge; outputs are checked at that
// same point, so each check sees the result of the edge just taken.
module tb_clk_div_prog;

  logic clk_in = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  clk_div_prog_if #(.WIDTH(8)) bus ();

  clk_div_prog #(.WIDTH(8), .DIV_RESET(2)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Bit i of clk_exp/ce_exp is the expected value after the i-th edge.
  task automatic run_pat(input string tag, input int n,
                         input logic [15:0] clk_exp, input logic [15:0] ce_exp);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, "_clk"}, bus.clk_out, clk_exp[i]);
      chk({tag, "_ce"},  bus.ce_out,  ce_exp[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.div_in = '0;
    bus.div_load = 1'b0;
    bus.bit_slip = 1'b0;
    #3;
    chk("rst_clk",  bus.clk_out,  0);
    chk("rst_ce",   bus.ce_out,   0);
    chk("rst_cur",  bus.div_cur,  2);
    chk("rst_pend", bus.div_pend, 0);
    chk("rst_err",  bus.div_err,  0);
    tick();
    tick();
    rst = 1'b0;

    // N=2: toggles every cycle, CE every second cycle
    bus.en = 1'b1;
    run_pat("n2", 4, 16'b0101, 16'b0101);
    chk("n2_cur", bus.div_cur, 2);

    // load on the wrap edge bypasses pending
    bus.div_in = 8'd4; bus.div_load = 1'b1;
    tick();
    bus.div_load = 1'b0;
    chk("byp_cur",  bus.div_cur,  4);
    chk("byp_pend", bus.div_pend, 0);
    chk("byp_ce",   bus.ce_out,   1);
    tick();
    chk("n4_c1_clk", bus.clk_out, 1);

    // load 5 mid-period at N=4
    bus.div_in = 8'd5; bus.div_load = 1'b1;
    tick();
    bus.div_load = 1'b0;
    chk("l5_pend", bus.div_pend, 1);
    chk("l5_cur",  bus.div_cur,  4);
    chk("l5_clk",  bus.clk_out,  0);
    tick();
    chk("l5_pend2", bus.div_pend, 1);
    chk("l5_ce0",   bus.ce_out,   0);
    tick();
    chk("l5_swcur",  bus.div_cur,  5);
    chk("l5_swpend", bus.div_pend, 0);
    chk("l5_swce",   bus.ce_out,   1);
    run_pat("n5", 5, 16'b10001, 16'b10000);

    // load 7 then 3 before the boundary: latest wins
    bus.div_in = 8'd7; bus.div_load = 1'b1;
    tick();
    bus.div_in = 8'd3;
    tick();
    bus.div_load = 1'b0;
    chk("lw_pend", bus.div_pend, 1);
    chk("lw_cur",  bus.div_cur,  5);
    tick();
    tick();
    chk("lw_ce0", bus.ce_out, 0);
    tick();
    chk("lw_cur3", bus.div_cur,  3);
    chk("lw_pnd0", bus.div_pend, 0);
    chk("lw_ce",   bus.ce_out,   1);
    run_pat("n3", 6, 16'b100100, 16'b100100);

    // back to N=4
    bus.div_in = 8'd4; bus.div_load = 1'b1;
    tick();
    bus.div_load = 1'b0;
    tick();
    tick();
    chk("n4b_cur", bus.div_cur, 4);
    chk("n4b_ce",  bus.ce_out,  1);

    // slip mid-period, second slip while in SLIP ignored
    tick();
    chk("sl_c1_clk", bus.clk_out, 1);
    bus.bit_slip = 1'b1;
    tick();
    chk("sl_hold_clk", bus.clk_out, 1);
    chk("sl_hold_ce",  bus.ce_out,  0);
    tick();
    bus.bit_slip = 1'b0;
    chk("sl_ign_clk", bus.clk_out, 0);
    tick();
    chk("sl_c3_ce", bus.ce_out, 0);
    tick();
    chk("sl_end_ce",  bus.ce_out,  1);
    chk("sl_end_clk", bus.clk_out, 1);
    run_pat("n4", 4, 16'b1001, 16'b1000);

    // slip on the wrap edge defers the pending swap
    bus.div_in = 8'd6; bus.div_load = 1'b1;
    tick();
    bus.div_load = 1'b0;
    tick();
    tick();
    chk("sw_pend", bus.div_pend, 1);
    bus.bit_slip = 1'b1;
    tick();
    bus.bit_slip = 1'b0;
    chk("sw_ce",   bus.ce_out,   0);
    chk("sw_clk",  bus.clk_out,  0);
    chk("sw_pnd",  bus.div_pend, 1);
    chk("sw_cur",  bus.div_cur,  4);
    tick();
    chk("sw2_ce",  bus.ce_out,   1);
    chk("sw2_clk", bus.clk_out,  1);
    chk("sw2_cur", bus.div_cur,  6);
    chk("sw2_pnd", bus.div_pend, 0);

    // rejected loads
    bus.div_in = 8'd0; bus.div_load = 1'b1;
    tick();
    chk("e0_err",  bus.div_err,  1);
    chk("e0_cur",  bus.div_cur,  6);
    chk("e0_pend", bus.div_pend, 0);
    bus.div_in = 8'd1;
    tick();
    bus.div_load = 1'b0;
    chk("e1_err", bus.div_err, 1);
    tick();
    chk("e_clr",  bus.div_err, 0);
    chk("n6_clk", bus.clk_out, 0);
    tick();
    tick();
    tick();
    chk("n6_ce", bus.ce_out, 1);

    // pending load, then rejected load that must not disturb it
    bus.div_in = 8'd9; bus.div_load = 1'b1;
    tick();
    bus.div_in = 8'd1;
    tick();
    bus.div_load = 1'b0;
    chk("ep_err",  bus.div_err,  1);
    chk("ep_pend", bus.div_pend, 1);
    chk("ep_cur",  bus.div_cur,  6);
    chk("ep_clk",  bus.clk_out,  1);

    // asynchronous reset in the high phase with a load pending
    #3;
    rst = 1'b1;
    #1;
    chk("ar_clk",  bus.clk_out,  0);
    chk("ar_ce",   bus.ce_out,   0);
    chk("ar_cur",  bus.div_cur,  2);
    chk("ar_pend", bus.div_pend, 0);
    chk("ar_err",  bus.div_err,  0);
    tick();
    bus.en = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("enlo_clk", bus.clk_out, 0);
      chk("enlo_ce",  bus.ce_out,  0);
    end
    bus.en = 1'b1;
    tick();
    chk("enhi_ce",  bus.ce_out,  1);
    chk("enhi_clk", bus.clk_out, 1);
    chk("enhi_cur", bus.div_cur, 2);

    // pending divisor survives EN low and is applied at restart
    bus.div_in = 8'd3; bus.div_load = 1'b1;
    tick();
    bus.div_load = 1'b0;
    bus.en = 1'b0;
    tick();
    chk("pk_clk",  bus.clk_out,  0);
    chk("pk_ce",   bus.ce_out,   0);
    chk("pk_pend", bus.div_pend, 1);
    chk("pk_cur",  bus.div_cur,  2);
    tick();
    bus.en = 1'b1;
    tick();
    chk("pk_cur3", bus.div_cur,  3);
    chk("pk_pnd0", bus.div_pend, 0);
    chk("pk_ce1",  bus.ce_out,   1);
    run_pat("n3b", 3, 16'b100, 16'b100);

    // load together with EN low is applied directly
    bus.en = 1'b0;
    bus.div_in = 8'd7; bus.div_load = 1'b1;
    tick();
    bus.div_load = 1'b0;
    chk("ld_cur",  bus.div_cur,  7);
    chk("ld_pend", bus.div_pend, 0);
    chk("ld_clk",  bus.clk_out,  0);
    bus.en = 1'b1;
    tick();
    chk("ld_ce",   bus.ce_out,   1);
    chk("ld_cur2", bus.div_cur,  7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
